wb_stage: RTL and testbench



---
 rtl/wb_stage_pkg.sv | 20 ++
 rtl/wb_stage_if.sv | 29 ++
 rtl/wb_stage_load_align.sv | 27 ++
 rtl/wb_stage.sv | 83 ++++++++
 tb/tb_wb_stage.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared opcode-class defines, load funct3 codes and writeback state encoding
package wb_stage_pkg;
   localparam int OP_INFO_WIDTH = 8;
   localparam int OP_ALU = 0;
   localparam int OP_LOAD = 1;
   localparam int OP_STORE = 2;
   localparam int OP_BRANCH = 3;
   localparam int OP_JAL = 4;
   localparam int OP_JALR = 5;
   localparam int OP_SYSTEM = 6;
   localparam int OP_FENCE = 7;
   localparam logic [2:0] LB = 3'b000;
   localparam logic [2:0] LH = 3'b001;
   localparam logic [2:0] LW = 3'b010;
   localparam logic [2:0] LD = 3'b011;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] LWU = 3'b110;
   typedef enum logic {IDLE = 1'b0, WAIT_LOAD = 1'b1} wb_state_e;
endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: retiring-instruction handshake from the memory stage plus the load response
interface wb_stage_if #(
   parameter int XLEN = 32,
   parameter int OFFW = $clog2(XLEN / 8)
);
   import wb_stage_pkg::*;
   logic in_valid;
   logic in_ready;
   logic rd_wen;
   logic [4:0] rd_idx;
   logic [OP_INFO_WIDTH-1:0] opcode_info;
   logic [2:0] funct3;
   logic [OFFW-1:0] addr_lo;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] csr_rdata;
   logic mem_rsp_valid;
   logic [XLEN-1:0] mem_rsp_data;
   modport master (
      output in_valid, rd_wen, rd_idx, opcode_info, funct3, addr_lo, pc, alu_res, csr_rdata,
      output mem_rsp_valid, mem_rsp_data,
      input in_ready
   );
   modport slave (
      input in_valid, rd_wen, rd_idx, opcode_info, funct3, addr_lo, pc, alu_res, csr_rdata,
      input mem_rsp_valid, mem_rsp_data,
      output in_ready
   );
endinterface

// File: rtl/wb_stage_load_align.sv
// load_align: shifts a raw aligned word down to the addressed element and sign/zero-extends it
module load_align
   import wb_stage_pkg::*;
#(
   parameter int XLEN = 32,
   localparam int OFFW = $clog2(XLEN / 8)
) (
   input  logic [XLEN-1:0] data,
   input  logic [2:0]      funct3,
   input  logic [OFFW-1:0] off,
   output logic [XLEN-1:0] res
);
   logic [OFFW-1:0] off_a;
   logic [XLEN-1:0] s;
   always_comb begin
      // funct3[1:0] is log2 of the access size, so it gives the alignment mask directly
      off_a = off & ~OFFW'((4'd1 << funct3[1:0]) - 4'd1);
      s = data >> {off_a, 3'b000};
      res = funct3 == LB  ? XLEN'($signed(s[7:0])) :
            funct3 == LH  ? XLEN'($signed(s[15:0])) :
            funct3 == LW  ? XLEN'($signed(s[31:0])) :
            funct3 == LD && XLEN == 64 ? s :
            funct3 == LBU ? XLEN'(s[7:0]) :
            funct3 == LHU ? XLEN'(s[15:0]) :
                            XLEN'(s[31:0]);
   end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: registered writeback stage; selects result source, waits for load data, times out stuck loads
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int LOAD_TIMEOUT = 16,
   localparam int OFFW = $clog2(XLEN / 8)
) (
   input  logic            clk,
   input  logic            rst,
   wb_stage_if.slave       up,
   output logic            wb_rd_wen,
   output logic [4:0]      wb_rd_idx,
   output logic [XLEN-1:0] wb_rd_wdata,
   output logic            load_err
);
   localparam int CW = $clog2(LOAD_TIMEOUT + 1);
   wb_state_e state, state_n;
   logic [CW-1:0] cnt;
   logic l_wen;
   logic [4:0] l_idx;
   logic [2:0] l_f3;
   logic [OFFW-1:0] l_off;
   logic accept, is_load, rsp, tmo;
   logic wen_n;
   logic [XLEN-1:0] res, ld_data, wdata_n;
   logic [4:0] idx_n;
   assign up.in_ready = state == IDLE;
   assign accept = up.in_valid & up.in_ready;
   assign is_load = up.opcode_info[OP_LOAD];
   assign rsp = (state == WAIT_LOAD) & up.mem_rsp_valid;
   // a response in the last allowed cycle still wins over the timeout
   assign tmo = (state == WAIT_LOAD) & ~up.mem_rsp_valid & (cnt == CW'(LOAD_TIMEOUT - 1));
   assign res = up.opcode_info[OP_SYSTEM] ? up.csr_rdata :
                (up.opcode_info[OP_JAL] | up.opcode_info[OP_JALR]) ? up.pc + XLEN'(4) :
                up.alu_res;
   load_align #(.XLEN(XLEN)) u_align (
      .data(up.mem_rsp_data),
      .funct3(l_f3),
      .off(l_off),
      .res(ld_data)
   );
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state == IDLE ? (accept & is_load ? WAIT_LOAD : IDLE) :
                (rsp | tmo) ? IDLE : WAIT_LOAD;
   end
   always_comb begin
      wen_n = rsp ? l_wen & (l_idx != 5'd0) :
              accept & ~is_load & up.rd_wen & (up.rd_idx != 5'd0);
      idx_n = rsp ? l_idx : up.rd_idx;
      wdata_n = rsp ? ld_data : res;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         l_wen <= 1'b0;
         l_idx <= '0;
         l_f3 <= '0;
         l_off <= '0;
         wb_rd_wen <= 1'b0;
         wb_rd_idx <= '0;
         wb_rd_wdata <= '0;
         load_err <= 1'b0;
      end else begin
         cnt <= accept ? '0 : state == WAIT_LOAD ? cnt + CW'(1) : cnt;
         wb_rd_wen <= wen_n;
         load_err <= tmo;
         if (wen_n) begin
            wb_rd_idx <= idx_n;
            wb_rd_wdata <= wdata_n;
         end
         if (accept & is_load) begin
            l_wen <= up.rd_wen;
            l_idx <= up.rd_idx;
            l_f3 <= up.funct3;
            l_off <= up.addr_lo;
         end
      end
   end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage at XLEN=32 and XLEN=64, LOAD_TIMEOUT=4
module tb_wb_stage;
   import wb_stage_pkg::*;
   localparam int LT = 4;
   typedef struct packed {logic [4:0] idx; logic [63:0] data;} exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   wb_stage_if #(.XLEN(32)) b32 ();
   wb_stage_if #(.XLEN(64)) b64 ();
   logic w32_wen, w32_err, w64_wen, w64_err;
   logic [4:0] w32_idx, w64_idx;
   logic [31:0] w32_wdata;
   logic [63:0] w64_wdata;
   wb_stage #(.XLEN(32), .LOAD_TIMEOUT(LT)) d32 (
      .clk(clk), .rst(rst), .up(b32), .wb_rd_wen(w32_wen), .wb_rd_idx(w32_idx),
      .wb_rd_wdata(w32_wdata), .load_err(w32_err)
   );
   wb_stage #(.XLEN(64), .LOAD_TIMEOUT(LT)) d64 (
      .clk(clk), .rst(rst), .up(b64), .wb_rd_wen(w64_wen), .wb_rd_idx(w64_idx),
      .wb_rd_wdata(w64_wdata), .load_err(w64_err)
   );
   int cmp = 0;
   int bad = 0;
   int errc[2] = '{0, 0};
   exp_t q32[$], q64[$];
   exp_t m32, m64;
   always @(negedge clk) begin
      if (w32_err) errc[0]++;
      if (w32_wen) begin
         cmp++;
         if (q32.size() == 0) begin
            bad++;
            $display("FAIL wr32: unexpected write idx=%0d data=%h, expected no write", w32_idx, w32_wdata);
         end else begin
            m32 = q32.pop_front();
            if (w32_idx !== m32.idx || w32_wdata !== m32.data[31:0]) begin
               bad++;
               $display("FAIL wr32: got idx=%0d data=%h, expected idx=%0d data=%h", w32_idx, w32_wdata, m32.idx, m32.data[31:0]);
            end
         end
      end
   end
   always @(negedge clk) begin
      if (w64_err) errc[1]++;
      if (w64_wen) begin
         cmp++;
         if (q64.size() == 0) begin
            bad++;
            $display("FAIL wr64: unexpected write idx=%0d data=%h, expected no write", w64_idx, w64_wdata);
         end else begin
            m64 = q64.pop_front();
            if (w64_idx !== m64.idx || w64_wdata !== m64.data) begin
               bad++;
               $display("FAIL wr64: got idx=%0d data=%h, expected idx=%0d data=%h", w64_idx, w64_wdata, m64.idx, m64.data);
            end
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end
   function automatic logic [OP_INFO_WIDTH-1:0] oh(input int i);
      return OP_INFO_WIDTH'(1) << i;
   endfunction
   function automatic logic rdy(input bit w);
      return w ? b64.in_ready : b32.in_ready;
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drv(input bit w, input logic v, input logic [OP_INFO_WIDTH-1:0] oi, input logic rw,
                      input logic [4:0] idx, input logic [2:0] f3, input logic [2:0] off,
                      input logic [63:0] pc, input logic [63:0] alu, input logic [63:0] csr);
      if (w) begin
         b64.in_valid = v; b64.opcode_info = oi; b64.rd_wen = rw; b64.rd_idx = idx;
         b64.funct3 = f3; b64.addr_lo = off; b64.pc = pc; b64.alu_res = alu; b64.csr_rdata = csr;
      end else begin
         b32.in_valid = v; b32.opcode_info = oi; b32.rd_wen = rw; b32.rd_idx = idx;
         b32.funct3 = f3; b32.addr_lo = off[1:0]; b32.pc = pc[31:0]; b32.alu_res = alu[31:0];
         b32.csr_rdata = csr[31:0];
      end
   endtask
   task automatic idle(input bit w);
      drv(w, 1'b0, '0, 1'b0, 5'd0, 3'd0, 3'd0, 64'd0, 64'd0, 64'd0);
   endtask
   task automatic rsp(input bit w, input logic v, input logic [63:0] d);
      if (w) begin b64.mem_rsp_valid = v; b64.mem_rsp_data = d; end
      else begin b32.mem_rsp_valid = v; b32.mem_rsp_data = d[31:0]; end
   endtask
   task automatic push(input bit w, input logic [4:0] i, input logic [63:0] d);
      exp_t e;
      e.idx = i;
      e.data = d;
      if (w) q64.push_back(e);
      else q32.push_back(e);
   endtask
   task automatic check_drained(input bit w, input string name);
      int n;
      n = w ? q64.size() : q32.size();
      cmp++;
      if (n != 0) begin
         bad++;
         $display("FAIL %s: %0d expected writes never appeared, expected 0 pending", name, n);
      end
   endtask
   // Issues a load; the response arrives after wait_n empty wait cycles, or never when wait_n >= LT.
   task automatic do_load(input bit w, input logic [2:0] f3, input logic [2:0] off, input logic [4:0] rd,
                          input logic [63:0] data, input int wait_n, input logic [63:0] exp);
      int low, e0, want_low;
      bit to, wr;
      low = 0;
      to = wait_n >= LT;
      wr = !to && rd != 5'd0;
      want_low = to ? LT : wait_n + 1;
      e0 = errc[w];
      drv(w, 1'b1, oh(OP_LOAD), 1'b1, rd, f3, off, 64'h40, 64'hDEADBEEF_DEADBEEF, 64'h5555);
      tick();
      idle(w);
      for (int i = 0; i < 20; i++) begin
         rsp(w, i == wait_n, data);
         if (i == wait_n && wr) push(w, rd, exp);
         if (rdy(w)) break;
         low++;
         tick();
      end
      rsp(w, 1'b0, 64'd0);
      tick();
      tick();
      cmp++;
      if (low != want_low) begin
         bad++;
         $display("FAIL load_ready_low f3=%0d: in_ready low %0d cycles, expected %0d", f3, low, want_low);
      end
      cmp++;
      if (errc[w] - e0 != (to ? 1 : 0)) begin
         bad++;
         $display("FAIL load_err f3=%0d: %0d error pulses, expected %0d", f3, errc[w] - e0, to ? 1 : 0);
      end
      check_drained(w, "load_write");
   endtask
   task automatic test_reset();
      rst = 1'b1;
      idle(0); idle(1);
      rsp(0, 1'b0, 64'd0); rsp(1, 1'b0, 64'd0);
      tick(); tick();
      rst = 1'b0;
      cmp++;
      if (b32.in_ready !== 1'b1 || b64.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready: got %b/%b, expected 1/1", b32.in_ready, b64.in_ready);
      end
      cmp++;
      if ({w32_wen, w32_idx, w32_wdata, w32_err} !== '0) begin
         bad++;
         $display("FAIL reset_out32: wen=%b idx=%0d data=%h err=%b, expected all 0", w32_wen, w32_idx, w32_wdata, w32_err);
      end
      cmp++;
      if ({w64_wen, w64_idx, w64_wdata, w64_err} !== '0) begin
         bad++;
         $display("FAIL reset_out64: wen=%b idx=%0d data=%h err=%b, expected all 0", w64_wen, w64_idx, w64_wdata, w64_err);
      end
   endtask
   task automatic test_alu();
      logic [4:0] rd;
      logic [31:0] d;
      drv(0, 1'b1, oh(OP_ALU), 1'b1, 5'd5, 3'd0, 3'd0, 64'h80, 64'h1234, 64'h99);
      push(0, 5'd5, 64'h1234);
      tick();
      cmp++;
      if (w32_wen !== 1'b1 || w32_idx !== 5'd5 || w32_wdata !== 32'h1234) begin
         bad++;
         $display("FAIL alu_latency: wen=%b idx=%0d data=%h, expected 1/5/00001234", w32_wen, w32_idx, w32_wdata);
      end
      for (int i = 0; i < 8; i++) begin
         rd = 5'($urandom_range(1, 31));
         d = $urandom;
         drv(0, 1'b1, oh(OP_ALU), 1'b1, rd, 3'd0, 3'd0, 64'h100, {32'd0, d}, 64'h77);
         push(0, rd, {32'd0, d});
         tick();
         cmp++;
         if (b32.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL alu_b2b_ready: got %b, expected 1", b32.in_ready);
         end
      end
      idle(0);
      tick(); tick();
      check_drained(0, "alu_b2b");
   endtask
   task automatic test_x0();
      drv(0, 1'b1, oh(OP_ALU), 1'b1, 5'd0, 3'd0, 3'd0, 64'd0, 64'hFFFF, 64'd0);
      tick();
      cmp++;
      if (w32_wen !== 1'b0) begin
         bad++;
         $display("FAIL x0_write: wen=%b, expected 0", w32_wen);
      end
      drv(0, 1'b1, oh(OP_ALU), 1'b0, 5'd3, 3'd0, 3'd0, 64'd0, 64'hABCD, 64'd0);
      tick();
      cmp++;
      if (w32_wen !== 1'b0) begin
         bad++;
         $display("FAIL no_rd_wen: wen=%b, expected 0", w32_wen);
      end
      idle(0);
      tick();
   endtask
   task automatic test_jump_csr();
      drv(0, 1'b1, oh(OP_JALR), 1'b1, 5'd1, 3'd0, 3'd0, 64'hFFFFFFFC, 64'h1111, 64'h2222);
      push(0, 5'd1, 64'h0);
      tick();
      drv(0, 1'b1, oh(OP_JAL), 1'b1, 5'd2, 3'd0, 3'd0, 64'h7FFFFFFC, 64'h1111, 64'h2222);
      push(0, 5'd2, 64'h80000000);
      tick();
      drv(0, 1'b1, oh(OP_SYSTEM), 1'b1, 5'd3, 3'd1, 3'd0, 64'h200, 64'h1111, 64'hDEAD);
      push(0, 5'd3, 64'hDEAD);
      tick();
      drv(0, 1'b1, oh(OP_ALU), 1'b1, 5'd4, 3'd0, 3'd0, 64'h200, 64'h1111, 64'hDEAD);
      push(0, 5'd4, 64'h1111);
      tick();
      idle(0);
      tick(); tick();
      check_drained(0, "jump_csr");
   endtask
   task automatic test_load32();
      do_load(0, LB, 3'd3, 5'd7, 64'h80AABBCC, 2, 64'hFFFFFF80);
      do_load(0, LBU, 3'd3, 5'd8, 64'h80AABBCC, 1, 64'h00000080);
      do_load(0, LH, 3'd2, 5'd9, 64'h80AABBCC, 0, 64'hFFFF80AA);
      do_load(0, LHU, 3'd3, 5'd10, 64'h80AABBCC, 2, 64'h000080AA);
      do_load(0, LW, 3'd1, 5'd11, 64'h80AABBCC, 0, 64'h80AABBCC);
      do_load(0, LB, 3'd1, 5'd12, 64'h80AABBCC, 1, 64'hFFFFFFBB);
      do_load(0, LW, 3'd0, 5'd0, 64'h12345678, 1, 64'h0);
   endtask
   task automatic test_timeout();
      do_load(0, LB, 3'd0, 5'd13, 64'h11223344, 99, 64'h0);
      do_load(0, LBU, 3'd0, 5'd14, 64'h112233CC, LT - 1, 64'h000000CC);
   endtask
   task automatic test_rst_wait(input bit w);
      int e0;
      e0 = errc[w];
      drv(w, 1'b1, oh(OP_LOAD), 1'b1, 5'd9, LB, 3'd0, 64'd0, 64'd0, 64'd0);
      tick();
      idle(w);
      tick(); tick();
      cmp++;
      if (rdy(w) !== 1'b0) begin
         bad++;
         $display("FAIL rst_wait_busy%0d: in_ready=%b, expected 0", w, rdy(w));
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rsp(w, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
      cmp++;
      if (rdy(w) !== 1'b1) begin
         bad++;
         $display("FAIL rst_wait_ready%0d: in_ready=%b, expected 1", w, rdy(w));
      end
      tick();
      rsp(w, 1'b0, 64'd0);
      tick(); tick();
      cmp++;
      if (errc[w] != e0) begin
         bad++;
         $display("FAIL rst_wait_err%0d: %0d error pulses, expected 0", w, errc[w] - e0);
      end
      check_drained(w, "rst_wait");
   endtask
   task automatic test_load64();
      drv(1, 1'b1, oh(OP_ALU), 1'b1, 5'd6, 3'd0, 3'd0, 64'd0, 64'hCAFE0000_12345678, 64'd0);
      push(1, 5'd6, 64'hCAFE0000_12345678);
      tick();
      drv(1, 1'b1, oh(OP_JAL), 1'b1, 5'd1, 3'd0, 3'd0, 64'hFFFFFFFF_FFFFFFFC, 64'd1, 64'd2);
      push(1, 5'd1, 64'h0);
      tick();
      drv(1, 1'b1, oh(OP_JALR), 1'b1, 5'd2, 3'd0, 3'd0, 64'h00000000_FFFFFFFC, 64'd1, 64'd2);
      push(1, 5'd2, 64'h00000001_00000000);
      tick();
      idle(1);
      tick(); tick();
      check_drained(1, "alu64");
      do_load(1, LWU, 3'd4, 5'd20, 64'h80000001_12345678, 1, 64'h00000000_80000001);
      do_load(1, LD, 3'd0, 5'd21, 64'h80000001_12345678, 0, 64'h80000001_12345678);
      do_load(1, LD, 3'd5, 5'd22, 64'h80000001_12345678, 2, 64'h80000001_12345678);
      do_load(1, LW, 3'd4, 5'd23, 64'h80000001_12345678, 1, 64'hFFFFFFFF_80000001);
      do_load(1, LW, 3'd0, 5'd24, 64'h80000001_12345678, 0, 64'h00000000_12345678);
      do_load(1, LH, 3'd7, 5'd25, 64'h80000001_12345678, 1, 64'hFFFFFFFF_FFFF8000);
      do_load(1, LBU, 3'd4, 5'd26, 64'h80000001_12345678, 0, 64'h00000000_00000001);
      do_load(1, LD, 3'd0, 5'd27, 64'h80000001_12345678, 99, 64'h0);
   endtask
   initial begin
      test_reset();
      test_alu();
      test_x0();
      test_jump_csr();
      test_load32();
      test_timeout();
      test_rst_wait(0);
      test_load64();
      test_rst_wait(1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end
endmodule
